// File: rtl/fma_writeback_buffer.sv
// fma_writeback_buffer: collects one result per FMA lane, then drains the
// lanes selected by the batch mask onto a single memory write port, one beat
// per handshake, at sequential addresses from a latched base.
module fma_writeback_buffer #(
    parameter int WIDTH      = 4,
    parameter int FMA_COUNT  = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [WIDTH-1:0]      d_in         [FMA_COUNT-1:0],
    input  logic                  d_valid_in   [FMA_COUNT-1:0],
    input  logic [FMA_COUNT-1:0]  lane_mask_in,
    input  logic [ADDR_WIDTH-1:0] base_addr_in,
    output logic                  ready_out,
    output logic [WIDTH-1:0]      data_out,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  data_valid_out,
    input  logic                  data_ready_in,
    output logic                  done_out
);

    localparam int IDX_W = (FMA_COUNT > 1) ? $clog2(FMA_COUNT) : 1;

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_DRAIN   = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [WIDTH-1:0]      r_buf      [FMA_COUNT-1:0];
    logic [WIDTH-1:0]      w_buf_next [FMA_COUNT-1:0];
    logic [FMA_COUNT-1:0]  r_captured;
    logic [FMA_COUNT-1:0]  r_mask;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [IDX_W-1:0]      r_idx;
    logic [WIDTH-1:0]      r_data;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_done;

    logic [FMA_COUNT-1:0]  w_new_cap;
    logic [FMA_COUNT-1:0]  w_cap_all;
    logic [FMA_COUNT-1:0]  w_above;
    logic                  w_start;
    logic                  w_hs;
    logic                  w_last;
    logic [IDX_W-1:0]      w_first_idx;
    logic [IDX_W-1:0]      w_next_idx;

    // Lowest set bit of a lane mask (0 when the mask is empty).
    function automatic logic [IDX_W-1:0] first_set(input logic [FMA_COUNT-1:0] m);
        first_set = '0;
        for (int i = FMA_COUNT - 1; i >= 0; i--) begin
            if (m[i]) first_set = IDX_W'(i);
        end
    endfunction

    // Capture newly valid, not-yet-captured lanes while collecting; first value wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_new_cap  = '0;
        w_buf_next = r_buf;
        for (int i = 0; i < FMA_COUNT; i++) begin
            if (r_state == S_COLLECT && d_valid_in[i] && !r_captured[i]) begin
                w_new_cap[i]  = 1'b1;
                w_buf_next[i] = d_in[i];
            end
        end
    end

    // Drain walk: masked lanes strictly above the current index.
    always_comb begin
        w_above = '0;
        for (int i = 0; i < FMA_COUNT; i++) begin
            w_above[i] = r_mask[i] && (i > int'(r_idx));
        end
    end

    assign w_cap_all   = r_captured | w_new_cap;
    assign w_start     = (r_state == S_COLLECT) && (lane_mask_in != '0) &&
                         ((w_cap_all & lane_mask_in) == lane_mask_in);
    assign w_first_idx = first_set(lane_mask_in);
    assign w_next_idx  = first_set(w_above);
    assign w_last      = (w_above == '0);
    assign w_hs        = (r_state == S_DRAIN) && data_ready_in;

    // FSM state register.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst_in) r_state <= S_COLLECT;
        else        r_state <= w_state_next;
    end

    // FSM next state: leave COLLECT once the mask is covered, leave DRAIN on the last beat.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_COLLECT: if (w_start)          w_state_next = S_DRAIN;
            S_DRAIN:   if (w_hs && w_last)   w_state_next = S_COLLECT;
            default:                         w_state_next = S_COLLECT;
        endcase
    end

    // Result storage; validity is tracked by r_captured, so the contents need no reset.
    always_ff @(posedge clk_in) begin
        // NOTE: data storage is deliberately not reset; a lane is only read after r_captured marks it written.
        r_buf <= w_buf_next;
    end

    // Batch control and registered write-port outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_captured <= '0;
            r_mask     <= '0;
            r_base     <= '0;
            r_idx      <= '0;
            r_data     <= '0;
            r_addr     <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_hs && w_last;
            if (w_start) begin
                r_captured <= w_cap_all;
                r_mask     <= lane_mask_in;
                r_base     <= base_addr_in;
                r_idx      <= w_first_idx;
                r_data     <= w_buf_next[w_first_idx];
                r_addr     <= base_addr_in + ADDR_WIDTH'(w_first_idx);
            end else if (r_state == S_COLLECT) begin
                r_captured <= w_cap_all;
            end else if (w_hs) begin
                if (w_last) begin
                    // Batch finished: release all lanes, outputs keep the last beat.
                    r_captured <= '0;
                end else begin
                    r_idx  <= w_next_idx;
                    r_data <= r_buf[w_next_idx];
                    r_addr <= r_base + ADDR_WIDTH'(w_next_idx);
                end
            end
        end
    end

    assign ready_out      = (r_state == S_COLLECT);
    assign data_valid_out = (r_state == S_DRAIN);
    assign data_out       = r_data;
    assign addr_out       = r_addr;
    assign done_out       = r_done;

endmodule

// File: tb/tb_fma_writeback_buffer.sv
// Testbench for fma_writeback_buffer: directed scenarios plus randomized
// batches; expected beats are queued at stimulus time and checked by a
// separate monitor whenever the write port handshakes or done pulses.
module tb_fma_writeback_buffer;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [3:0] d_in       [3:0];
    logic       d_valid_in [3:0];
    logic [3:0] lane_mask_in;
    logic [7:0] base_addr_in;
    logic       ready_out;
    logic [3:0] data_out;
    logic [7:0] addr_out;
    logic       data_valid_out;
    logic       data_ready_in;
    logic       done_out;

    typedef struct {
        bit       is_done;
        bit [7:0] addr;
        bit [3:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   rnd_ready = 0;

    fma_writeback_buffer #(.WIDTH(4), .FMA_COUNT(4), .ADDR_WIDTH(8)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .d_in           (d_in),
        .d_valid_in     (d_valid_in),
        .lane_mask_in   (lane_mask_in),
        .base_addr_in   (base_addr_in),
        .ready_out      (ready_out),
        .data_out       (data_out),
        .addr_out       (addr_out),
        .data_valid_out (data_valid_out),
        .data_ready_in  (data_ready_in),
        .done_out       (done_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        if (rnd_ready) data_ready_in = ($urandom_range(0, 3) != 0);
    endtask

    task automatic push_beat(input bit [7:0] a, input bit [3:0] d);
        exp_t e;
        e.is_done = 0; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1; e.addr = '0; e.data = '0;
        exp_q.push_back(e);
    endtask

    task automatic clear_valids();
        for (int i = 0; i < 4; i++) d_valid_in[i] = 1'b0;
    endtask

    task automatic set_all(input bit [3:0] d0, input bit [3:0] d1,
                           input bit [3:0] d2, input bit [3:0] d3);
        d_in[0] = d0; d_in[1] = d1; d_in[2] = d2; d_in[3] = d3;
        for (int i = 0; i < 4; i++) d_valid_in[i] = 1'b1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
    endtask

    // Bounded wait for the done pulse, sampled after each edge.
    task automatic wait_done(input string name);
        bit seen = 0;
        for (int c = 0; c < 80 && !seen; c++) begin
            if (done_out) seen = 1;
            else step();
        end
        check(name, 32'(seen), 1);
    endtask

    // Scoreboard monitor: every handshake and every done pulse consumes one expectation.
    always @(negedge clk_in) begin
        exp_t e;
        if (data_valid_out && data_ready_in) begin
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_beat: got addr %0h data %0h, expected none", addr_out, data_out);
            end else begin
                e = exp_q.pop_front();
                check("beat_order", 32'(e.is_done), 0);
                check("beat_addr", 32'(addr_out), 32'(e.addr));
                check("beat_data", 32'(data_out), 32'(e.data));
            end
        end
        if (done_out) begin
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_done: got done_out 1, expected 0");
            end else begin
                e = exp_q.pop_front();
                check("done_order", 32'(e.is_done), 1);
            end
        end
    end

    // Randomized batch: the model keeps the first value seen per lane and
    // knows the batch closes on the cycle the mask becomes fully covered.
    task automatic run_random_batch();
        bit [3:0] mask;
        bit [7:0] base;
        bit [3:0] vals [4];
        bit [3:0] got;
        bit [3:0] d;
        bit       v;
        mask = 4'($urandom_range(1, 15));
        base = 8'($urandom);
        got  = '0;
        lane_mask_in = mask;
        base_addr_in = base;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < 4; i++) begin
                v = (c >= 8) || ($urandom_range(0, 2) == 0);
                d = 4'($urandom);
                d_valid_in[i] = v;
                d_in[i] = d;
                if (v && !got[i]) begin
                    got[i]  = 1'b1;
                    vals[i] = d;
                end
            end
            if ((got & mask) == mask) begin
                for (int i = 0; i < 4; i++)
                    if (mask[i]) push_beat(8'(int'(base) + i), vals[i]);
                push_done();
                step();
                // Junk during the drain must be ignored.
                for (int i = 0; i < 4; i++) begin
                    d_valid_in[i] = ($urandom_range(0, 1) == 1);
                    d_in[i] = 4'($urandom);
                end
                lane_mask_in = 4'($urandom);
                base_addr_in = 8'($urandom);
                step();
                clear_valids();
                wait_done("rand_done");
                return;
            end
            step();
        end
    endtask

    initial begin
        int cnt;
        rst_in        = 1'b1;
        clear_valids();
        for (int i = 0; i < 4; i++) d_in[i] = '0;
        lane_mask_in  = '0;
        base_addr_in  = '0;
        data_ready_in = 1'b1;
        do_reset();

        // Reset state
        check("rst_ready", 32'(ready_out), 1);
        check("rst_valid", 32'(data_valid_out), 0);
        check("rst_done", 32'(done_out), 0);
        check("rst_data", 32'(data_out), 0);
        check("rst_addr", 32'(addr_out), 0);

        // 1: full batch in one cycle, ready held high
        lane_mask_in = 4'b1111; base_addr_in = 8'h10;
        set_all(4'h1, 4'h2, 4'h4, 4'h8);
        push_beat(8'h10, 4'h1); push_beat(8'h11, 4'h2);
        push_beat(8'h12, 4'h4); push_beat(8'h13, 4'h8); push_done();
        step();
        clear_valids();
        check("t1_first_beat_valid", 32'(data_valid_out), 1);
        cnt = 0;
        while (!ready_out && cnt < 20) begin cnt++; step(); end
        check("t1_ready_low_cycles", 32'(cnt), 4);
        check("t1_done_pulse", 32'(done_out), 1);
        step();
        check("t1_done_one_cycle", 32'(done_out), 0);

        // 2: staggered lanes, lane 0 re-valid ignored
        lane_mask_in = 4'b1111; base_addr_in = 8'h30;
        d_in[0] = 4'h6; d_valid_in[0] = 1'b1; d_in[2] = 4'hA; d_valid_in[2] = 1'b1;
        step();
        clear_valids();
        check("t2_no_beat_c0", 32'(data_valid_out), 0);
        d_in[0] = 4'hF; d_valid_in[0] = 1'b1;
        step();
        clear_valids();
        check("t2_no_beat_c1", 32'(data_valid_out), 0);
        step();
        check("t2_no_beat_c2", 32'(data_valid_out), 0);
        d_in[1] = 4'hB; d_valid_in[1] = 1'b1; d_in[3] = 4'hC; d_valid_in[3] = 1'b1;
        push_beat(8'h30, 4'h6); push_beat(8'h31, 4'hB);
        push_beat(8'h32, 4'hA); push_beat(8'h33, 4'hC); push_done();
        step();
        clear_valids();
        check("t2_beat_c4", 32'(data_valid_out), 1);
        wait_done("t2_done");

        // 3: sparse mask with address wrap
        lane_mask_in = 4'b1010; base_addr_in = 8'hFF;
        set_all(4'h3, 4'h5, 4'h7, 4'h9);
        push_beat(8'h00, 4'h5); push_beat(8'h02, 4'h9); push_done();
        step();
        clear_valids();
        cnt = 0;
        while (!ready_out && cnt < 20) begin cnt++; step(); end
        check("t3_two_beats", 32'(cnt), 2);
        check("t3_done", 32'(done_out), 1);

        // 4: stall on beat 1
        lane_mask_in = 4'b1111; base_addr_in = 8'h40;
        set_all(4'h1, 4'h3, 4'h5, 4'h7);
        push_beat(8'h40, 4'h1); push_beat(8'h41, 4'h3);
        push_beat(8'h42, 4'h5); push_beat(8'h43, 4'h7); push_done();
        step();
        clear_valids();
        step();
        data_ready_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("t4_stall_valid", 32'(data_valid_out), 1);
            check("t4_stall_data", 32'(data_out), 32'h3);
            check("t4_stall_addr", 32'(addr_out), 32'h41);
            step();
        end
        check("t4_held_data", 32'(data_out), 32'h3);
        data_ready_in = 1'b1;
        wait_done("t4_done");

        // 5: reset in the middle of a drain
        lane_mask_in = 4'b1111; base_addr_in = 8'h20;
        set_all(4'h2, 4'h4, 4'h6, 4'h8);
        push_beat(8'h20, 4'h2);
        step();
        clear_valids();
        step();
        rst_in = 1'b1; data_ready_in = 1'b0;
        step();
        rst_in = 1'b0; data_ready_in = 1'b1;
        check("t5_valid_after_rst", 32'(data_valid_out), 0);
        check("t5_ready_after_rst", 32'(ready_out), 1);
        check("t5_data_after_rst", 32'(data_out), 0);
        repeat (5) step();
        check("t5_queue_drained", 32'(exp_q.size()), 0);
        base_addr_in = 8'h50;
        set_all(4'h9, 4'hA, 4'hB, 4'hC);
        push_beat(8'h50, 4'h9); push_beat(8'h51, 4'hA);
        push_beat(8'h52, 4'hB); push_beat(8'h53, 4'hC); push_done();
        step();
        clear_valids();
        wait_done("t5_fresh_done");

        // 6: empty mask never drains
        lane_mask_in = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            set_all(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            step();
            check("t6_ready", 32'(ready_out), 1);
            check("t6_no_valid", 32'(data_valid_out), 0);
        end
        clear_valids();
        do_reset();

        // Randomized batches with random back-pressure
        rnd_ready = 1;
        for (int b = 0; b < 60; b++) run_random_batch();
        rnd_ready = 0;
        data_ready_in = 1'b1;
        repeat (3) step();

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fma_writeback_buffer.md
Name: fma_writeback_buffer

Overview:
Return-path counterpart of the FMA operand memory buffer. Captures one WIDTH-bit result per FMA lane and holds it until every enabled lane has reported. It then drains the results one per handshake onto a single memory write port, with sequential addresses from a latched base. It sits between the FMA array outputs and shared memory.

Parameters:
WIDTH, 4, bit width of one FMA result word
FMA_COUNT, 4, number of FMA lanes
ADDR_WIDTH, 8, memory write address width

Ports:
clk_in  input  1  system clock, all logic on rising edge
rst_in  input  1  synchronous active-high reset
d_in  input  WIDTH x FMA_COUNT (unpacked [FMA_COUNT-1:0])  per-lane result
d_valid_in  input  1 x FMA_COUNT (unpacked)  per-lane result valid
lane_mask_in  input  FMA_COUNT  lanes required this batch (bit i = lane i)
base_addr_in  input  ADDR_WIDTH  write address of lane 0 of the batch
ready_out  output  1  high = buffer accepting lane results
data_out  output  WIDTH  write data
addr_out  output  ADDR_WIDTH  write address
data_valid_out  output  1  write beat valid
data_ready_in  input  1  memory accepts beat
done_out  output  1  one-cycle pulse, batch fully written

Behaviour:
- Reset (rst_in high at an edge): state COLLECT, captured mask 0, drain index 0. Outputs: ready_out=1, data_out=0, addr_out=0, data_valid_out=0, done_out=0. Reset mid-DRAIN abandons the batch; no further beats.
- States: COLLECT, DRAIN.
- COLLECT: ready_out=1, data_valid_out=0. Each lane i with d_valid_in[i]=1 and captured[i]=0 stores d_in[i] and sets captured[i].
  - Re-valid on an already-captured lane is ignored (first value wins).
  - Lanes with lane_mask_in[i]=0 are still captured but never written.
  - Transition to DRAIN when (captured | this cycle's new captures) covers lane_mask_in, evaluated at that edge. base_addr_in is latched on the same edge. The final capture and the transition can happen in the same cycle.
  - lane_mask_in=0: stay in COLLECT, never drain.
  - lane_mask_in is only sampled in COLLECT.
- DRAIN: ready_out=0; all d_valid_in ignored.
  - Drain index starts at the lowest masked lane and walks ascending, skipping unmasked lanes.
  - data_out = buffer[idx]; addr_out = latched_base + idx, truncated to ADDR_WIDTH, wrapping modulo 2^ADDR_WIDTH.
  - data_valid_out=1 throughout DRAIN. data_out/addr_out stay stable while data_ready_in=0.
  - Handshake = data_valid_out & data_ready_in. It advances to the next masked lane the following cycle.
  - Handshake on the last masked lane: next cycle is COLLECT, done_out=1 for exactly that cycle, captured mask cleared, ready_out=1. Lane results can be captured in that same cycle.
- Latency: all masked lanes valid in cycle t → first beat valid in t+1. With data_ready_in held high, N masked lanes take beats t+1..t+N, and done_out fires at t+N+1.
- data_out/addr_out hold their last driven value outside DRAIN; they are 0 after reset.

Test Plan:
1. Mask 4'b1111, base 8'h10, all lanes valid in one cycle with d=1,2,4,8, ready held high → beats (10,1),(11,2),(12,4),(13,8) on consecutive cycles, done_out one cycle later, ready_out low for exactly 4 cycles.
2. Mask 4'b1111; lanes 0,2 valid in cycle 0, lanes 1,3 in cycle 3; lane 0 re-valid with d=F in cycle 1 → no beat before cycle 4; lane 0 beat carries the original value, not F.
3. Mask 4'b1010, base 8'hFF, d=3,5,7,9 → exactly two beats: (00,5) then (02,9), showing wrap and the lane skip; done_out after the second beat.
4. Mask 4'b1111, data_ready_in low for 3 cycles on beat 1, otherwise high → data_out/addr_out held stable through the stall; no beat lost or duplicated; done_out after 4 handshakes.
5. rst_in pulsed during DRAIN after beat 0 → data_valid_out=0 next cycle, ready_out=1, done_out never fires; a fresh full batch afterwards drains normally from lane 0.
6. Mask 4'b0000 with lanes valid → ready_out stays 1, data_valid_out never asserts.
